// File: rtl/matmul_pkg.sv
// matmul_pkg: shared FSM state encoding and a constant-evaluable ceil(log2) helper.
package matmul_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/matmul_accel_param_if.sv
// matmul_accel_param_if: start/base controls plus input-RAM and result-RAM buses of the accelerator.
interface matmul_accel_param_if #(
  parameter int N = 4,
  parameter int EW = 16,
  parameter int ADDR_WIDTH = 4
);
  logic comp_enb;
  logic [ADDR_WIDTH-1:0] a_base, b_base, c_base, mem_addr, res_addr;
  logic mem_read_enb, mem_write_enb, busyb, done;
  logic [N*EW-1:0] mem_data, res_data;
  modport master (
    output comp_enb, a_base, b_base, c_base, mem_data,
    input mem_addr, mem_read_enb, mem_write_enb, res_addr, res_data, busyb, done
  );
  modport slave (
    input comp_enb, a_base, b_base, c_base, mem_data,
    output mem_addr, mem_read_enb, mem_write_enb, res_addr, res_data, busyb, done
  );
endinterface

// File: rtl/matmul_dot.sv
// matmul_dot: combinational N-lane unsigned dot product of packed EW-bit vectors.
module matmul_dot
  import matmul_pkg::*;
#(
  parameter int N = 4,
  parameter int EW = 16,
  localparam int ACCW = 2 * EW + clog2(N)
) (
  input  logic [N*EW-1:0] a,
  input  logic [N*EW-1:0] b,
  output logic [ACCW-1:0] sum
);
  always_comb begin
    sum = '0;
    for (int k = 0; k < N; k++)
      sum = sum + ACCW'(a[k*EW +: EW]) * ACCW'(b[k*EW +: EW]);
  end
endmodule

// File: rtl/matmul_accel_param.sv
// matmul_accel_param: N x N unsigned matrix multiply, RAM in, RAM out, one element per cycle.
// Define MATMUL_SAT_EN to saturate elements to 2^EW-1 instead of keeping the low EW bits.
module matmul_accel_param
  import matmul_pkg::*;
#(
  parameter int N = 4,
  parameter int EW = 16,
  parameter int ADDR_WIDTH = 4
) (
  input logic clk,
  input logic rst,
  matmul_accel_param_if.slave bus
);
  localparam int DW = N * EW;
  localparam int ACCW = 2 * EW + clog2(N);
  localparam int CW = clog2(2 * N + 1);
  localparam int IW = clog2(N + 1);
  state_t st, st_n;
  logic [CW-1:0] cnt, cnt_n, nxt;
  logic [IW-1:0] ri, ri_n, cj, cj_n;
  logic [ADDR_WIDTH-1:0] ab, bb, cb, addr_n, raddr_n;
  logic rd_n, wr_n, busyb_n, done_n;
  logic [DW-1:0] rf [2*N];
  logic [EW-1:0] rowbuf [N];
  logic [DW-1:0] arow, bcol, row_n, rdata_n;
  logic [ACCW-1:0] sum;
  logic [EW-1:0] red;

  matmul_dot #(.N(N), .EW(EW)) dot (.a(arow), .b(bcol), .sum(sum));

`ifdef MATMUL_SAT_EN
  assign red = (sum > ACCW'({EW{1'b1}})) ? '1 : EW'(sum);
`else
  assign red = EW'(sum);
`endif

  // rows 0..N-1 of rf hold A, rows N..2N-1 hold B; column cj of B is gathered here
  always_comb begin
    arow = '0;
    bcol = '0;
    row_n = '0;
    for (int r = 0; r < N; r++) begin
      if (int'(ri) == r) arow = rf[r];
      row_n[r*EW +: EW] = (int'(cj) == r) ? red : rowbuf[r];
      for (int k = 0; k < N; k++)
        if (int'(cj) == r) bcol[k*EW +: EW] = rf[N+k][r*EW +: EW];
    end
  end

  always_comb begin
    st_n = st;
    cnt_n = cnt;
    ri_n = ri;
    cj_n = cj;
    nxt = cnt + CW'(1);
    rd_n = 1'b0;
    wr_n = 1'b0;
    done_n = 1'b0;
    busyb_n = bus.busyb;
    addr_n = bus.mem_addr;
    raddr_n = bus.res_addr;
    rdata_n = bus.res_data;
    case (st)
      IDLE: if (bus.comp_enb) begin
        st_n = LOAD;
        cnt_n = '0;
        rd_n = 1'b1;
        addr_n = bus.a_base;
        busyb_n = 1'b0;
      end
      LOAD: begin
        cnt_n = nxt;
        rd_n = int'(nxt) < 2 * N;
        addr_n = !rd_n ? bus.mem_addr :
                 int'(nxt) < N ? ab + ADDR_WIDTH'(nxt) : bb + ADDR_WIDTH'(int'(nxt) - N);
        if (int'(cnt) == 2 * N) begin
          st_n = CALC;
          ri_n = '0;
          cj_n = '0;
        end
      end
      CALC: begin
        cj_n = (int'(cj) == N - 1) ? '0 : cj + IW'(1);
        if (int'(cj) == N - 1) begin
          ri_n = ri + IW'(1);
          wr_n = 1'b1;
          raddr_n = cb + ADDR_WIDTH'(ri);
          rdata_n = row_n;
          if (int'(ri) == N - 1) begin
            st_n = DONE;
            done_n = 1'b1;
          end
        end
      end
      default: begin
        st_n = IDLE;
        busyb_n = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      cnt <= '0;
      ri <= '0;
      cj <= '0;
      bus.mem_addr <= '0;
      bus.mem_read_enb <= 1'b0;
      bus.mem_write_enb <= 1'b0;
      bus.res_addr <= '0;
      bus.res_data <= '0;
      bus.busyb <= 1'b1;
      bus.done <= 1'b0;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      ri <= ri_n;
      cj <= cj_n;
      bus.mem_addr <= addr_n;
      bus.mem_read_enb <= rd_n;
      bus.mem_write_enb <= wr_n;
      bus.res_addr <= raddr_n;
      bus.res_data <= rdata_n;
      bus.busyb <= busyb_n;
      bus.done <= done_n;
    end
  end

  // read data for the read issued at count c arrives while count is c+1
  always_ff @(posedge clk) begin
    if (st == IDLE && bus.comp_enb) begin
      ab <= bus.a_base;
      bb <= bus.b_base;
      cb <= bus.c_base;
    end
    for (int r = 0; r < 2 * N; r++)
      if (st == LOAD && int'(cnt) == r + 1) rf[r] <= bus.mem_data;
    for (int r = 0; r < N; r++)
      if (st == CALC && int'(cj) == r) rowbuf[r] <= red;
  end
endmodule
